vc_pop_arbiter: RTL

//  Read side of the two virtual-channel FIFOs (VC0, VC1). Pops VC0 with strict priority over VC1.

---
 rtl/vc_pop_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/vc_pop_arbiter.sv
// Pops VC0 (strict priority) or VC1 and steers each word to D0/D1 by its destination bit.
// Latency: pop in cycle N, push in cycle N+1; sustains one word per cycle back to back.
// Backpressure: either downstream almost-full stops new pops at once; the in-flight word is always pushed.
module vc_pop_arbiter #(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = 4,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 fifo_empty_vc0,
    input  logic                 fifo_empty_vc1,
    input  logic [DATA_SIZE-1:0] data_mux_0,
    input  logic [DATA_SIZE-1:0] data_mux_1,
    input  logic                 pause_d0,
    input  logic                 pause_d1,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic [1:0]           state_o,
    output logic [CNT_W-1:0]     cnt_d0,
    output logic [CNT_W-1:0]     cnt_d1
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        PAUSED = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic                 vld_q, vld_d;
    logic                 src_q, src_d;
    logic [CNT_W-1:0]     cnt_d0_q, cnt_d0_d;
    logic [CNT_W-1:0]     cnt_d1_q, cnt_d1_d;
    logic                 pause_any;
    logic                 go;
    logic [DATA_SIZE-1:0] word;

    assign pause_any = pause_d0 | pause_d1;

    // Dropping enable wins over any pause transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!enable)        state_d = IDLE;
                else if (pause_any) state_d = PAUSED;
            end
            PAUSED: begin
                if (!enable)         state_d = IDLE;
                else if (!pause_any) state_d = ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The destination is only known after the read, so both pauses gate every pop.
    always_comb begin
        go       = (state_q == ACTIVE) & enable & ~pause_any;
        pop_vc0  = go & ~fifo_empty_vc0;
        pop_vc1  = go & fifo_empty_vc0 & ~fifo_empty_vc1;
        vld_d    = pop_vc0 | pop_vc1;
        src_d    = pop_vc1;

        word     = src_q ? data_mux_1 : data_mux_0;
        push_d0  = vld_q & ~word[DEST_BIT];
        push_d1  = vld_q & word[DEST_BIT];
        data_d0  = push_d0 ? word : '0;
        data_d1  = push_d1 ? word : '0;

        cnt_d0_d = push_d0 ? cnt_d0_q + 1'b1 : cnt_d0_q;
        cnt_d1_d = push_d1 ? cnt_d1_q + 1'b1 : cnt_d1_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            vld_q    <= 1'b0;
            src_q    <= 1'b0;
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
        end else begin
            state_q  <= state_d;
            vld_q    <= vld_d;
            src_q    <= src_d;
            cnt_d0_q <= cnt_d0_d;
            cnt_d1_q <= cnt_d1_d;
        end
    end

    assign state_o = state_q;
    assign cnt_d0  = cnt_d0_q;
    assign cnt_d1  = cnt_d1_q;

endmodule
